// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Turns load-use, branch, syscall/eret and data-memory wait conditions into
// per-stage stall/flush, PC write-enable and PC-select controls. A two-state
// machine with a timeout counter sequences multi-cycle memory accesses.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             idex_mem_r,
    input  logic [4:0]       idex_rt_addr,
    input  logic             ex_nop,
    input  logic             ex_branch_taken,
    input  logic             ex_syscall,
    input  logic             ex_eret,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_w_en,
    output logic [1:0]       pc_sel,
    output logic             epc_w_en,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             cu_stall,
    output logic             cu_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] SEL_PC4  = 2'd0;
    localparam logic [1:0] SEL_BR   = 2'd1;
    localparam logic [1:0] SEL_EXC  = 2'd2;
    localparam logic [1:0] SEL_EPC  = 2'd3;
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] next_wait;
    logic       mem_stall;
    logic       exc_hit;
    logic       eret_hit;
    logic       branch_hit;
    logic       load_use;

    // Hazard conditions; memory wait covers both the first miss cycle in RUN
    // and every not-ready cycle in MEM_WAIT.
    always_comb begin
        mem_stall  = ((state == MEM_WAIT) || mem_req) && !mem_ready;
        exc_hit    = ex_syscall && !ex_nop;
        eret_hit   = ex_eret && !ex_nop;
        branch_hit = ex_branch_taken && !ex_nop;
        load_use   = idex_mem_r && !ex_nop && (idex_rt_addr != 5'd0) &&
                     ((id_uses_rs && (id_rs_addr == idex_rt_addr)) ||
                      (id_uses_rt && (id_rt_addr == idex_rt_addr)));
        next_wait  = (state == MEM_WAIT) ? wait_cnt + 8'd1 : 8'd1;
    end

    // Control outputs in priority order: reset > memory wait > syscall >
    // eret > branch > load-use > normal.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_w_en     = 1'b1;
        pc_sel      = SEL_PC4;
        epc_w_en    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        cu_stall    = 1'b0;
        cu_flush    = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_stall = 1'b0;
        if (reset) begin
            pc_w_en     = 1'b0;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_stall) begin
            pc_w_en     = 1'b0;
            ifid_stall  = 1'b1;
            cu_stall    = 1'b1;
            exmem_stall = 1'b1;
            memwb_stall = 1'b1;
        end else if (exc_hit) begin
            pc_sel      = SEL_EXC;
            epc_w_en    = 1'b1;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
        end else if (eret_hit) begin
            pc_sel      = SEL_EPC;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
        end else if (branch_hit) begin
            pc_sel      = SEL_BR;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID and PC, inject a bubble into EX for one cycle.
            pc_w_en     = 1'b0;
            ifid_stall  = 1'b1;
            cu_flush    = 1'b1;
        end
    end

    // Memory-wait FSM, timeout pulse and stall performance counter.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mem_err <= 1'b0;
            if (!pc_w_en) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mem_stall) begin
                if (next_wait >= TIMEOUT) begin
                    // Give up on the access and let the pipeline resume.
                    mem_err  <= 1'b1;
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end else begin
                    state    <= MEM_WAIT;
                    wait_cnt <= next_wait;
                end
            end else begin
                state    <= RUN;
                wait_cnt <= 8'd0;
            end
        end
    end

endmodule
